// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controller: phase codes, lamp patterns
// and a small helper for sizing the phase timer.
package traffic_pkg;

  localparam logic [2:0] NS_GRN   = 3'd0;
  localparam logic [2:0] NS_YEL   = 3'd1;
  localparam logic [2:0] ALLRED_A = 3'd2;
  localparam logic [2:0] EW_GRN   = 3'd3;
  localparam logic [2:0] EW_YEL   = 3'd4;
  localparam logic [2:0] WALK     = 3'd5;
  localparam logic [2:0] ALLRED_B = 3'd6;

  typedef enum logic [2:0] {
    StNsGrn   = NS_GRN,
    StNsYel   = NS_YEL,
    StAllredA = ALLRED_A,
    StEwGrn   = EW_GRN,
    StEwYel   = EW_YEL,
    StWalk    = WALK,
    StAllredB = ALLRED_B
  } state_e;

  // Lamp vectors are indexed [0:2] = {green, yellow, red}
  localparam logic [0:2] LAMP_GREEN  = 3'b100;
  localparam logic [0:2] LAMP_YELLOW = 3'b010;
  localparam logic [0:2] LAMP_RED    = 3'b001;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/intersection_ctrl_if.sv
// Sensor inputs and lamp outputs of the intersection controller.
// The controller takes the slave side; the board/bench takes the master side.
interface intersection_ctrl_if;
  logic       ew_car;
  logic       ped_btn;
  logic [0:2] ns_ld;
  logic [0:2] ew_ld;
  logic       walk;
  logic       ped_wait;

  modport master (
    output ew_car, ped_btn,
    input  ns_ld, ew_ld, walk, ped_wait
  );

  modport slave (
    input  ew_car, ped_btn,
    output ns_ld, ew_ld, walk, ped_wait
  );
endinterface

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// restart forces the count back to zero so a new phase starts on a full period.
module tick_divider #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-head traffic light sequencer with pedestrian walk phase. NS rests green
// until a side-road car or latched pedestrian request pulls the cycle round.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned GREEN_TICKS  = 10,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned WALK_TICKS   = 8
) (
  input logic               clk,
  input logic               rst,
  intersection_ctrl_if.slave bus
);

  localparam int unsigned MaxTicks =
    max_of(max_of(GREEN_TICKS, YELLOW_TICKS), max_of(ALLRED_TICKS, WALK_TICKS));
  localparam int unsigned TimerW = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

  typedef logic [TimerW-1:0] timer_t;

  function automatic timer_t load_val(input state_e s);
    case (s)
      StNsGrn, StEwGrn:     return timer_t'(GREEN_TICKS - 1);
      StNsYel, StEwYel:     return timer_t'(YELLOW_TICKS - 1);
      StWalk:               return timer_t'(WALK_TICKS - 1);
      default:              return timer_t'(ALLRED_TICKS - 1);
    endcase
  endfunction

  state_e     state_q, state_d;
  timer_t     timer_q, timer_d;
  logic       ped_q, ped_d;
  logic [0:2] ns_q, ns_d, ew_q, ew_d;
  logic       walk_q, walk_d;
  logic       tick, restart;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    if (tick && (timer_q == '0)) begin
      case (state_q)
        StNsGrn:   if (bus.ew_car || ped_q) state_d = StNsYel;
        StNsYel:   state_d = StAllredA;
        StAllredA: state_d = ped_q ? StWalk : StEwGrn;
        StEwGrn:   state_d = StEwYel;
        StEwYel:   state_d = StAllredB;
        StWalk:    state_d = StAllredB;
        StAllredB: state_d = StNsGrn;
        default:   state_d = StAllredB;
      endcase
    end

    restart = (state_d != state_q);

    // NS green rest keeps the timer parked at zero and re-checks every tick
    timer_d = timer_q;
    if (restart)                         timer_d = load_val(state_d);
    else if (tick && (timer_q != '0))    timer_d = timer_q - timer_t'(1);

    // Clear wins over a press on WALK entry and throughout WALK
    ped_d = ped_q | bus.ped_btn;
    if ((state_d == StWalk) || (state_q == StWalk)) ped_d = 1'b0;

    ns_d   = LAMP_RED;
    ew_d   = LAMP_RED;
    walk_d = 1'b0;
    case (state_d)
      StNsGrn: ns_d   = LAMP_GREEN;
      StNsYel: ns_d   = LAMP_YELLOW;
      StEwGrn: ew_d   = LAMP_GREEN;
      StEwYel: ew_d   = LAMP_YELLOW;
      StWalk:  walk_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAllredB;
      timer_q <= timer_t'(ALLRED_TICKS - 1);
      ped_q   <= 1'b0;
      ns_q    <= LAMP_RED;
      ew_q    <= LAMP_RED;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ped_q   <= ped_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      walk_q  <= walk_d;
    end
  end

  assign bus.ns_ld    = ns_q;
  assign bus.ew_ld    = ew_q;
  assign bus.walk     = walk_q;
  assign bus.ped_wait = ped_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl with a fast tick (TICK_DIV=4) so every
// phase length below is ticks*4 clocks, checked phase by phase.
module tb_intersection_ctrl;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   viol  = 0;

  always #5 clk = ~clk;

  intersection_ctrl_if bus ();

  intersection_ctrl #(
    .TICK_DIV     (4),
    .GREEN_TICKS  (3),
    .YELLOW_TICKS (2),
    .ALLRED_TICKS (1),
    .WALK_TICKS   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Counts cycles in the window whose outputs all match, then checks the count
  task automatic expect_phase(input string tag, input logic [2:0] ns_e, input logic [2:0] ew_e,
                              input logic walk_e, input logic pw_e, input int n);
    int good;
    good = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ns_ld == ns_e && bus.ew_ld == ew_e && bus.walk == walk_e && bus.ped_wait == pw_e)
        good++;
    end
    check(tag, 32'(good), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ns"}, 32'(bus.ns_ld), 32'(R));
    check({tag, "_ew"}, 32'(bus.ew_ld), 32'(R));
    check({tag, "_walk"}, 32'(bus.walk), 32'(0));
    check({tag, "_pw"}, 32'(bus.ped_wait), 32'(0));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ns_ld != R && bus.ew_ld != R) viol++;
      if (bus.walk && (bus.ns_ld != R || bus.ew_ld != R)) viol++;
    end
  end

  initial begin
    bus.ew_car  = 1'b0;
    bus.ped_btn = 1'b0;

    // 1: reset -> all red, NS green on the 4th edge after release
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("t1_rst");
    expect_phase("t1_allred", R, R, 1'b0, 1'b0, 3);

    // 2: idle rest on NS green; 200 samples leave the divider on a tick cycle
    expect_phase("t2_rest", G, R, 1'b0, 1'b0, 200);

    // 3: held car runs the full EW cycle twice around
    bus.ew_car = 1'b1;
    expect_phase("t3_ns_yel", Y, R, 1'b0, 1'b0, 8);
    expect_phase("t3_allred_a", R, R, 1'b0, 1'b0, 4);
    expect_phase("t3_ew_grn", R, G, 1'b0, 1'b0, 12);
    expect_phase("t3_ew_yel", R, Y, 1'b0, 1'b0, 8);
    expect_phase("t3_allred_b", R, R, 1'b0, 1'b0, 4);
    expect_phase("t3_ns_grn", G, R, 1'b0, 1'b0, 12);
    expect_phase("t3_ns_yel2", Y, R, 1'b0, 1'b0, 8);
    expect_phase("t3_allred_a2", R, R, 1'b0, 1'b0, 4);
    expect_phase("t3_ew_grn2", R, G, 1'b0, 1'b0, 12);
    expect_phase("t3_ew_yel2", R, Y, 1'b0, 1'b0, 8);
    expect_phase("t3_allred_b2", R, R, 1'b0, 1'b0, 4);
    bus.ew_car = 1'b0;

    // 4: single-cycle press mid green with no car -> WALK
    expect_phase("t4_ns_rest", G, R, 1'b0, 1'b0, 14);
    bus.ped_btn = 1'b1;
    expect_phase("t4_latch", G, R, 1'b0, 1'b1, 1);
    bus.ped_btn = 1'b0;
    expect_phase("t4_ns_tail", G, R, 1'b0, 1'b1, 1);
    expect_phase("t4_ns_yel", Y, R, 1'b0, 1'b1, 8);
    expect_phase("t4_allred_a", R, R, 1'b0, 1'b1, 4);
    expect_phase("t4_walk", R, R, 1'b1, 1'b0, 8);
    expect_phase("t4_allred_b", R, R, 1'b0, 1'b0, 4);

    // 5: car and press together -> WALK first, then car served next cycle
    expect_phase("t5_ns_head", G, R, 1'b0, 1'b0, 4);
    bus.ew_car  = 1'b1;
    bus.ped_btn = 1'b1;
    expect_phase("t5_latch", G, R, 1'b0, 1'b1, 1);
    bus.ped_btn = 1'b0;
    expect_phase("t5_ns_min", G, R, 1'b0, 1'b1, 7);
    expect_phase("t5_ns_yel", Y, R, 1'b0, 1'b1, 8);
    expect_phase("t5_allred_a", R, R, 1'b0, 1'b1, 3);
    bus.ped_btn = 1'b1;
    expect_phase("t5_entry_press", R, R, 1'b0, 1'b1, 1);
    expect_phase("t5_walk_press", R, R, 1'b1, 1'b0, 8);
    bus.ped_btn = 1'b0;
    expect_phase("t5_allred_b", R, R, 1'b0, 1'b0, 4);
    expect_phase("t5_ns_grn", G, R, 1'b0, 1'b0, 12);
    expect_phase("t5_ns_yel2", Y, R, 1'b0, 1'b0, 8);
    expect_phase("t5_allred_a2", R, R, 1'b0, 1'b0, 4);
    bus.ped_btn = 1'b1;
    expect_phase("t5_ew_latch", R, G, 1'b0, 1'b1, 1);
    bus.ped_btn = 1'b0;
    expect_phase("t5_ew_grn", R, G, 1'b0, 1'b1, 3);

    // 6: async reset mid EW green, then the same start-up as test 1
    rst        = 1'b1;
    bus.ew_car = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (3) @(negedge clk);
    check_reset_outputs("t6_hold");
    rst = 1'b0;
    expect_phase("t6_allred", R, R, 1'b0, 1'b0, 3);
    expect_phase("t6_ns_grn", G, R, 1'b0, 1'b0, 8);

    check("no_overlap", 32'(viol), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
